// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution path: kernel size, packed window
// length and the window element index helper also used by the MAC stage.
package conv_pkg;

  localparam int K          = 3;
  localparam int VEC_LEN    = K * K;
  localparam int DEF_DATA_W = 8;

  function automatic int win_idx(input int r, input int c);
    return r * K + c;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image row of pixel storage. The read is combinational, so a read and a
// write to the same address in one cycle return the previously stored value.
module conv_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 28,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_addr,
  input  logic signed [DATA_W-1:0] i_wdata,
  output logic signed [DATA_W-1:0] o_rdata
);

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream 3x3 window generator feeding the convolution MAC stage.
// Build option CONV_WIN_STRIDE2_EN restricts output to stride-2 window anchors.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DATA_W-1:0]    pix_in,
  input  logic                        pix_valid,
  input  logic                        sof,
  output logic [DATA_W*VEC_LEN-1:0]   win_vec,
  output logic                        win_valid,
  output logic                        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] r_col, w_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row, w_row_nxt;
  logic          w_sof, w_last, w_emit, w_stride_ok;

  logic signed [DATA_W-1:0] w_lb0_rd, w_lb1_rd;
  logic signed [DATA_W-1:0] r_win     [K][K];
  logic signed [DATA_W-1:0] w_win_nxt [K][K];
  logic [DATA_W*VEC_LEN-1:0] w_win_pack;

  logic [DATA_W*VEC_LEN-1:0] r_win_vec;
  logic                      r_win_valid, r_frame_done;

  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  assign w_sof = sof & pix_valid;
  assign w_col = w_sof ? '0 : r_col;
  assign w_row = w_sof ? '0 : r_row;

  conv_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk     (clk),
    .i_we    (pix_valid),
    .i_addr  (w_col),
    .i_wdata (pix_in),
    .o_rdata (w_lb0_rd)
  );

  conv_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .i_we    (pix_valid),
    .i_addr  (w_col),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  always_comb begin
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
    end
  end

  assign w_last = (w_row == ROW_LAST) && (w_col == COL_LAST);

`ifdef CONV_WIN_STRIDE2_EN
  // (row-2) and (col-2) even is the same as row and col even.
  assign w_stride_ok = ~w_row[0] & ~w_col[0];
`else
  assign w_stride_ok = 1'b1;
`endif

  assign w_emit = (w_row >= RW'(2)) && (w_col >= CW'(2)) && w_stride_ok;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        w_win_nxt[r][c] = r_win[r][c+1];
      end
    end
    w_win_nxt[0][K-1] = w_lb1_rd;
    w_win_nxt[1][K-1] = w_lb0_rd;
    w_win_nxt[2][K-1] = pix_in;
    w_win_pack = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_win_pack[win_idx(r, c)*DATA_W +: DATA_W] = w_win_nxt[r][c];
      end
    end
  end

  // Stage p0 -> p1: window shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_win <= w_win_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_vec    <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= pix_valid & w_emit;
      r_frame_done <= pix_valid & w_last;
      if (pix_valid) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        if (w_emit) begin
          r_win_vec <= w_win_pack;
        end
      end
    end
  end

  assign win_vec    = r_win_vec;
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 28x28 and a 4x4 instance checked every cycle
// against a full-frame image model.
module tb_conv_window_gen;

  localparam int DW = 8;
  localparam int BW = 28;
  localparam int BH = 28;
  localparam int SW = 4;
  localparam int SH = 4;
`ifdef CONV_WIN_STRIDE2_EN
  localparam bit STRIDE2 = 1'b1;
`else
  localparam bit STRIDE2 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic signed [DW-1:0] b_pix, s_pix;
  logic                 b_vld, b_sof, s_vld, s_sof;
  logic [DW*9-1:0]      b_vec, s_vec;
  logic                 b_wv, b_fd, s_wv, s_fd;

  conv_window_gen #(.DATA_W(DW), .IMG_W(BW), .IMG_H(BH)) u_big (
    .clk(clk), .rst_n(rst_n), .pix_in(b_pix), .pix_valid(b_vld), .sof(b_sof),
    .win_vec(b_vec), .win_valid(b_wv), .frame_done(b_fd)
  );

  conv_window_gen #(.DATA_W(DW), .IMG_W(SW), .IMG_H(SH)) u_small (
    .clk(clk), .rst_n(rst_n), .pix_in(s_pix), .pix_valid(s_vld), .sof(s_sof),
    .win_vec(s_vec), .win_valid(s_wv), .frame_done(s_fd)
  );

  int checks = 0;
  int errors = 0;
  int m_row [2];
  int m_col [2];
  logic signed [DW-1:0] img [2][BH][BW];
  int win_cnt [2];
  int done_cnt [2];

  function automatic int exp_windows(input int w, input int h);
    if (STRIDE2) return ((w - 1) / 2) * ((h - 1) / 2);
    return (w - 2) * (h - 2);
  endfunction

  // Apply one cycle of input to one instance and check its outputs after the edge.
  task automatic drive(input int inst, input logic signed [DW-1:0] pix,
                       input logic vld, input logic sof);
    logic ev, ed, awv, afd;
    logic [DW*9-1:0] evec, avec;
    int w, h, r, c;
    w = inst ? SW : BW;
    h = inst ? SH : BH;
    ev = 1'b0;
    ed = 1'b0;
    evec = '0;
    if (vld) begin
      if (sof) begin
        m_row[inst] = 0;
        m_col[inst] = 0;
      end
      r = m_row[inst];
      c = m_col[inst];
      img[inst][r][c] = pix;
      ev = (r >= 2) && (c >= 2) && (!STRIDE2 || ((r % 2 == 0) && (c % 2 == 0)));
      if (ev) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            evec[(i*3+j)*DW +: DW] = img[inst][r-2+i][c-2+j];
      end
      ed = (r == h - 1) && (c == w - 1);
      if (c == w - 1) begin
        m_col[inst] = 0;
        m_row[inst] = (r == h - 1) ? 0 : r + 1;
      end else begin
        m_col[inst] = c + 1;
      end
    end
    if (inst == 1) begin
      s_pix = pix; s_vld = vld; s_sof = sof; b_vld = 1'b0; b_sof = 1'b0;
    end else begin
      b_pix = pix; b_vld = vld; b_sof = sof; s_vld = 1'b0; s_sof = 1'b0;
    end
    @(posedge clk);
    #1;
    awv  = (inst == 1) ? s_wv  : b_wv;
    afd  = (inst == 1) ? s_fd  : b_fd;
    avec = (inst == 1) ? s_vec : b_vec;
    checks++;
    assert (awv === ev) else begin
      errors++;
      $error("FAIL win_valid inst=%0d got=%b exp=%b", inst, awv, ev);
    end
    checks++;
    assert (afd === ed) else begin
      errors++;
      $error("FAIL frame_done inst=%0d got=%b exp=%b", inst, afd, ed);
    end
    if (ev) begin
      checks++;
      assert (avec === evec) else begin
        errors++;
        $error("FAIL win_vec inst=%0d got=%h exp=%h", inst, avec, evec);
      end
    end
    if (awv === 1'b1) win_cnt[inst]++;
    if (afd === 1'b1) done_cnt[inst]++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    b_vld = 1'b0; b_sof = 1'b0; s_vld = 1'b0; s_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert ({b_wv, b_fd, s_wv, s_fd} === 4'b0000) else begin
      errors++;
      $error("FAIL reset_flags got=%b exp=0000", {b_wv, b_fd, s_wv, s_fd});
    end
    checks++;
    assert (b_vec === '0) else begin
      errors++;
      $error("FAIL reset_vec_big got=%h exp=0", b_vec);
    end
    checks++;
    assert (s_vec === '0) else begin
      errors++;
      $error("FAIL reset_vec_small got=%h exp=0", s_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_row[i] = 0;
      m_col[i] = 0;
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int n, guard, first_idx;
    int ramp10 [9];
    logic [DW*9-1:0] exp10;
    int done_at [$];

    b_pix = '0; s_pix = '0;
    b_vld = 1'b0; b_sof = 1'b0; s_vld = 1'b0; s_sof = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // 4x4 ramp frame on the small instance
    ramp10 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int k = 0; k < 9; k++) exp10[k*DW +: DW] = DW'(ramp10[k]);
    win_cnt[1] = 0; done_cnt[1] = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, DW'(i), 1'b1, i == 0);
      if (i == 10) begin
        checks++;
        assert (s_vec === exp10) else begin
          errors++;
          $error("FAIL ramp4_first got=%h exp=%h", s_vec, exp10);
        end
      end
    end
    check_int("ramp4_windows", win_cnt[1], exp_windows(SW, SH));
    check_int("ramp4_done", done_cnt[1], 1);

    // 28x28 ramp with random gaps and stray sof on idle cycles
    win_cnt[0] = 0; done_cnt[0] = 0; n = 0; guard = 0;
    while (n < BW * BH && guard < 20000) begin
      guard++;
      if ($urandom_range(0, 1) == 1) begin
        drive(0, DW'(n % 128), 1'b1, n == 0);
        n++;
      end else begin
        drive(0, DW'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      end
    end
    check_int("gap_pixels", n, BW * BH);
    check_int("gap_windows", win_cnt[0], exp_windows(BW, BH));
    check_int("gap_done", done_cnt[0], 1);

    // Abandon a frame with reset, then a fresh full frame
    for (int i = 0; i < 40; i++) drive(0, DW'($urandom), 1'b1, 1'b0);
    do_reset();
    win_cnt[0] = 0; done_cnt[0] = 0;
    for (int i = 0; i < BW * BH; i++) drive(0, DW'($urandom), 1'b1, 1'b0);
    check_int("rst_windows", win_cnt[0], exp_windows(BW, BH));
    check_int("rst_done", done_cnt[0], 1);

    // sof resync in the middle of a frame
    for (int i = 0; i < 100; i++) drive(0, DW'(i), 1'b1, 1'b0);
    win_cnt[0] = 0; done_cnt[0] = 0; first_idx = -1;
    for (int k = 0; k < BW * BH; k++) begin
      drive(0, DW'($urandom), 1'b1, k == 0);
      if (first_idx < 0 && b_wv === 1'b1) first_idx = k;
    end
    check_int("sof_first_window", first_idx, 2 * BW + 2);
    check_int("sof_windows", win_cnt[0], exp_windows(BW, BH));

    // Two back-to-back frames with continuous valid
    win_cnt[0] = 0; done_cnt[0] = 0;
    for (int k = 0; k < 2 * BW * BH; k++) begin
      drive(0, DW'($urandom), 1'b1, 1'b0);
      if (b_fd === 1'b1) done_at.push_back(k);
    end
    check_int("b2b_done_count", done_at.size(), 2);
    if (done_at.size() == 2) check_int("b2b_done_spacing", done_at[1] - done_at[0], BW * BH);
    check_int("b2b_windows", win_cnt[0], 2 * exp_windows(BW, BH));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
